// File: rtl/des_key_sched_if.sv
// rtl/des_key_sched_if.sv - key-in / round-key-out handshake bundle for des_key_sched
interface des_key_sched_if;
    logic [63:0] key;
    logic        dec;
    logic        key_vld;
    logic        key_rdy;
    logic [47:0] rk;
    logic [3:0]  rk_idx;
    logic        rk_last;
    logic        rk_vld;
    logic        rk_rdy;

    modport master (
        output key, dec, key_vld, rk_rdy,
        input  key_rdy, rk, rk_idx, rk_last, rk_vld
    );

    modport slave (
        input  key, dec, key_vld, rk_rdy,
        output key_rdy, rk, rk_idx, rk_last, rk_vld
    );
endinterface

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - sequential DES key schedule: PC-1, per-round C/D rotation, PC-2
module des_key_sched (
    input  logic           clk,
    input  logic           rst_n,
    des_key_sched_if.slave kif
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic [55:0] pc1_w;
    logic        last_w;

    // FIPS bit n of the key is key[64-n]; parity bits never appear here.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
                k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
                k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
                k[4],  k[12], k[20], k[28],
                k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
                k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
                k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
                k[36], k[44], k[52], k[60]};
    endfunction

    // Input bit n of {C,D} is cd[56-n].
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
                cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
                cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
                cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
                cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
                cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
                cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
                cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
    endfunction

    function automatic logic single_shift(input logic [3:0] i);
        return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign pc1_w  = pc1(kif.key);
    assign last_w = (state_q == RUN) &&
                    ((!mode_q && idx_q == 4'd15) || (mode_q && idx_q == 4'd0));

    assign kif.key_rdy = (state_q == IDLE);
    assign kif.rk_vld  = (state_q == RUN);
    assign kif.rk      = pc2({c_q, d_q});
    assign kif.rk_idx  = idx_q;
    assign kif.rk_last = last_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (kif.key_vld) begin
                    mode_d  = kif.dec;
                    state_d = RUN;
                    // Decrypt starts at K16: the 28 total shift positions bring C16 back to C0.
                    if (kif.dec) begin
                        c_d   = pc1_w[55:28];
                        d_d   = pc1_w[27:0];
                        idx_d = 4'd15;
                    end else begin
                        c_d   = rot_l(pc1_w[55:28], 1'b1);
                        d_d   = rot_l(pc1_w[27:0], 1'b1);
                        idx_d = 4'd0;
                    end
                end
            end
            RUN: begin
                if (kif.rk_rdy) begin
                    if (last_w) begin
                        state_d = IDLE;
                    end else if (!mode_q) begin
                        idx_d = idx_q + 4'd1;
                        c_d   = rot_l(c_q, single_shift(idx_q + 4'd1));
                        d_d   = rot_l(d_q, single_shift(idx_q + 4'd1));
                    end else begin
                        idx_d = idx_q - 4'd1;
                        c_d   = rot_r(c_q, single_shift(idx_q));
                        d_d   = rot_r(d_q, single_shift(idx_q));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - self-checking bench for des_key_sched against a bit-array key schedule model
module tb_des_key_sched;
    logic clk;
    logic rst_n;
    des_key_sched_if kif ();

    des_key_sched dut (.clk(clk), .rst_n(rst_n), .kif(kif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    typedef struct {
        logic [63:0] key;
        bit          dec;
        int          pos;
        logic [47:0] exp_rk;
        logic [3:0]  exp_idx;
        logic        exp_last;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_rk  [16];
    logic [47:0] got_rk  [16];
    logic [3:0]  got_idx [16];
    logic        got_last[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Rounds computed from cumulative shift totals over FIPS-ordered bit arrays.
    function automatic void compute_model(input logic [63:0] k, input bit d);
        bit          c0[28];
        bit          d0[28];
        bit          cd[56];
        logic [63:0] t;
        logic [47:0] ks[16];
        logic [47:0] r;
        int          tot;
        for (int j = 0; j < 28; j++) begin
            t = k >> (64 - PC1[j]);      c0[j] = t[0];
            t = k >> (64 - PC1[28 + j]); d0[j] = t[0];
        end
        tot = 0;
        for (int rnd = 0; rnd < 16; rnd++) begin
            tot += (rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2;
            for (int j = 0; j < 28; j++) begin
                cd[j]      = c0[(j + tot) % 28];
                cd[28 + j] = d0[(j + tot) % 28];
            end
            r = '0;
            for (int b = 0; b < 48; b++) r = {r[46:0], cd[PC2[b] - 1]};
            ks[rnd] = r;
        end
        for (int i = 0; i < 16; i++) exp_rk[i] = d ? ks[15 - i] : ks[i];
    endfunction

    task automatic run_seq(input logic [63:0] k, input bit d, input int stall_pct,
                           input bit stall8, input bit inject, input logic [63:0] other);
        int          n = 0;
        int          guard = 0;
        int          st8 = 0;
        bit          held = 0;
        bit          r;
        logic [47:0] h_rk;
        logic [3:0]  h_idx;
        logic        h_last;
        @(negedge clk);
        kif.key = k; kif.dec = d; kif.key_vld = 1'b1; kif.rk_rdy = 1'b0;
        while (!kif.key_rdy && guard < 50) begin @(negedge clk); guard++; end
        if (!kif.key_rdy) chk("key_accept_timeout", 64'(kif.key_rdy), 64'd1);
        @(negedge clk);
        if (inject) begin kif.key = other; kif.dec = ~d; end
        else kif.key_vld = 1'b0;
        guard = 0;
        while (n < 16 && guard < 400) begin
            chk("rk_vld_in_run", 64'(kif.rk_vld), 64'd1);
            if (inject) chk("key_rdy_in_run", 64'(kif.key_rdy), 64'd0);
            if (held) begin
                chk("stall_rk",   64'(kif.rk),      64'(h_rk));
                chk("stall_idx",  64'(kif.rk_idx),  64'(h_idx));
                chk("stall_last", 64'(kif.rk_last), 64'(h_last));
            end
            r = ($urandom_range(0, 99) >= stall_pct);
            if (stall8 && kif.rk_idx == 4'd8 && st8 < 5) begin r = 1'b0; st8++; end
            kif.rk_rdy = r;
            if (r && kif.rk_vld) begin
                got_rk[n] = kif.rk; got_idx[n] = kif.rk_idx; got_last[n] = kif.rk_last;
                n++;
                held = 1'b0;
            end else begin
                held = kif.rk_vld; h_rk = kif.rk; h_idx = kif.rk_idx; h_last = kif.rk_last;
            end
            @(negedge clk);
            guard++;
        end
        kif.rk_rdy = 1'b0;
        if (n < 16) chk("seq_timeout", 64'(n), 64'd16);
        chk("key_rdy_after_last", 64'(kif.key_rdy), 64'd1);
        chk("rk_vld_after_last",  64'(kif.rk_vld),  64'd0);
    endtask

    task automatic check_vs_model(input string tag, input logic [63:0] k, input bit d);
        compute_model(k, d);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_rk"},   64'(got_rk[i]),   64'(exp_rk[i]));
            chk({tag, "_idx"},  64'(got_idx[i]),  d ? 64'(15 - i) : 64'(i));
            chk({tag, "_last"}, 64'(got_last[i]), (i == 15) ? 64'd1 : 64'd0);
        end
    endtask

    vec_t        vecs[6];
    logic [63:0] rk_key;
    bit          rk_dec;
    int          guard;

    initial begin
        vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 0,  48'h1B02EFFC7072, 4'd0,  1'b0};
        vecs[1] = '{64'h133457799BBCDFF1, 1'b0, 1,  48'h79AED9DBC9E5, 4'd1,  1'b0};
        vecs[2] = '{64'h133457799BBCDFF1, 1'b0, 15, 48'hCB3D8B0E17F5, 4'd15, 1'b1};
        vecs[3] = '{64'h133457799BBCDFF1, 1'b1, 0,  48'hCB3D8B0E17F5, 4'd15, 1'b0};
        vecs[4] = '{64'h133457799BBCDFF1, 1'b1, 1,  48'hBF918D3D3F0A, 4'd14, 1'b0};
        vecs[5] = '{64'h133457799BBCDFF1, 1'b1, 15, 48'h1B02EFFC7072, 4'd0,  1'b1};

        rst_n = 1'b0;
        kif.key = '0; kif.dec = 1'b0; kif.key_vld = 1'b0; kif.rk_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_key_rdy", 64'(kif.key_rdy), 64'd1);
        chk("rst_rk_vld",  64'(kif.rk_vld),  64'd0);
        chk("rst_rk",      64'(kif.rk),      64'd0);
        chk("rst_rk_idx",  64'(kif.rk_idx),  64'd0);
        chk("rst_rk_last", 64'(kif.rk_last), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key || vecs[i].dec != vecs[i-1].dec) begin
                run_seq(vecs[i].key, vecs[i].dec, 0, 1'b0, 1'b0, 64'd0);
                check_vs_model(vecs[i].dec ? "fips_dec" : "fips_enc", vecs[i].key, vecs[i].dec);
            end
            chk("vec_rk",   64'(got_rk[vecs[i].pos]),   64'(vecs[i].exp_rk));
            chk("vec_idx",  64'(got_idx[vecs[i].pos]),  64'(vecs[i].exp_idx));
            chk("vec_last", 64'(got_last[vecs[i].pos]), 64'(vecs[i].exp_last));
        end

        run_seq(64'h133457799BBCDFF1, 1'b0, 35, 1'b1, 1'b0, 64'd0);
        check_vs_model("stall_enc", 64'h133457799BBCDFF1, 1'b0);

        run_seq(64'h0, 1'b0, 0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) chk("zero_key", 64'(got_rk[i]), 64'h0);
        run_seq(64'hFFFFFFFFFFFFFFFF, 1'b1, 0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) chk("ones_key", 64'(got_rk[i]), 64'hFFFFFFFFFFFF);
        run_seq(64'hFEFEFEFEFEFEFEFE, 1'b0, 0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) chk("parity_key", 64'(got_rk[i]), 64'hFFFFFFFFFFFF);

        for (int t = 0; t < 6; t++) begin
            rk_key = {$urandom, $urandom};
            rk_dec = 1'($urandom_range(0, 1));
            run_seq(rk_key, rk_dec, 30, 1'b0, 1'b0, 64'd0);
            check_vs_model("rand", rk_key, rk_dec);
        end

        // Key held valid through a whole run; the queued key must start at the first IDLE cycle.
        rk_key = 64'h0123456789ABCDEF;
        run_seq(64'h133457799BBCDFF1, 1'b0, 20, 1'b0, 1'b1, rk_key);
        check_vs_model("inject_run", 64'h133457799BBCDFF1, 1'b0);
        @(negedge clk);
        kif.key_vld = 1'b0;
        compute_model(rk_key, 1'b1);
        chk("inject_next_vld", 64'(kif.rk_vld), 64'd1);
        chk("inject_next_rk",  64'(kif.rk),     64'(exp_rk[0]));
        chk("inject_next_idx", 64'(kif.rk_idx), 64'd15);

        kif.rk_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld",  64'(kif.rk_vld),  64'd0);
        chk("async_rst_rdy",  64'(kif.key_rdy), 64'd1);
        chk("async_rst_rk",   64'(kif.rk),      64'd0);
        chk("async_rst_last", 64'(kif.rk_last), 64'd0);
        kif.rk_rdy = 1'b0;
        guard = 0;
        while (guard < 2) begin @(negedge clk); guard++; end
        rst_n = 1'b1;
        run_seq(64'h133457799BBCDFF1, 1'b0, 0, 1'b0, 1'b0, 64'd0);
        chk("post_rst_first_idx", 64'(got_idx[0]), 64'd0);
        chk("post_rst_first_rk",  64'(got_rk[0]),  64'h1B02EFFC7072);
        check_vs_model("post_rst", 64'h133457799BBCDFF1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
